iir_sos_ctrl: RTL and testbench
===============================

Name: iir_sos_ctrl

Overview:
Sequencer and coefficient loader for a cascade of NUM_SEC biquad sections (iir_sos instances) sharing one control bus.
- Per accepted input sample, drives each section in turn: ce high for two c_clk cycles (mult_sel 0 then 1), then one ce-low cycle so the section latches its delay line and output.
- In idle, forwards host coefficient writes to the addressed section as a one-cycle c_we pulse.
- Sits between the sample source / host config port and the cascade datapath.

Parameters:
NUM_SEC, 4, number of cascaded sections (1..2**SEC_W)
SEC_W, 2, width of section index
COEFF_W, 16, coefficient word width (COEFF_WH+COEFF_FR of the sections)

Ports:
c_clk  in  1  clock
nrst  in  1  asynchronous reset, active-low
samp_vld  in  1  input sample valid
samp_rdy  out  1  controller can accept a sample
din_le  out  1  one-cycle load enable for the section-0 input register
cfg_vld  in  1  coefficient write request
cfg_rdy  out  1  coefficient write accepted this cycle when cfg_vld=1
cfg_sec  in  SEC_W  target section
cfg_addr  in  2  coefficient address (00 a0, 01 a1, 10 b)
cfg_data  in  COEFF_W  coefficient value
ce  out  NUM_SEC  per-section compute enable
mult_sel  out  1  shared a-coefficient select
c_we  out  NUM_SEC  per-section coefficient write enable
c_addr  out  2  shared coefficient address
c_in  out  COEFF_W  shared coefficient data
out_vld  out  1  cascade output valid (one-cycle pulse)
busy  out  1  sample in flight
cfg_err  out  1  one-cycle pulse: cfg_sec >= NUM_SEC, write dropped

Behaviour:
- Reset is asynchronous, active-low, on nrst. While nrst=0, all outputs are 0 and the FSM is in IDLE. samp_rdy=0 during reset.
- Reset mid-sample aborts the sample. ce falls to 0; no out_vld is generated.
- Timing: all outputs are registered on posedge c_clk and must be glitch-free, because ce gates section clocks. The only exceptions are samp_rdy and cfg_rdy, which are combinational from state.
- FSM states: IDLE, CFG, CALC0, CALC1, GAP. Section counter sec_idx has width SEC_W.
- IDLE, outputs: samp_rdy=1; cfg_rdy=!samp_vld.
- IDLE, transitions (priority order):
  - samp_vld → din_le pulse, sec_idx=0, go to CALC0.
  - else cfg_vld → go to CFG.
  - Sample has priority when both are requested in the same cycle.
- CFG (1 cycle): on acceptance, c_addr<=cfg_addr, c_in<=cfg_data, c_we[cfg_sec]<=1; then return to IDLE.
  - If cfg_sec >= NUM_SEC, c_we stays 0 and cfg_err pulses.
  - cfg_addr=11 is forwarded unchanged; sections ignore it.
- c_addr/c_in hold their last value outside CFG.
- CALC0: ce[sec_idx]=1, mult_sel=0.
- CALC1: ce[sec_idx]=1, mult_sel=1.
- GAP: ce all 0, mult_sel=0. The falling ce updates section sec_idx's output.
  - If sec_idx==NUM_SEC-1: out_vld=1 this cycle, go to IDLE.
  - Otherwise: sec_idx+1, go to CALC0.
- Only one ce bit is high at any time. ce is never high during CFG.
- busy=1 in CALC0/CALC1/GAP.
- Latency: samp_vld accepted at cycle t → out_vld at cycle t+3*NUM_SEC. Maximum sample rate is one sample per 3*NUM_SEC+1 cycles.
- samp_vld while busy is not accepted (samp_rdy=0); the source holds it.
- cfg_vld while busy is stalled (cfg_rdy=0) and accepted on return to IDLE, unless samp_vld is also high then.

Optional Feature:
IIR_CTRL_OVERRUN_EN:
- Defined: adds output ovr (1 bit, reset 0). ovr sets when samp_vld=1 and samp_rdy=0 for a sample that was not present the previous cycle (rising samp_vld while busy). It is sticky until input ovr_clr (1 bit) is pulsed; clr has priority over set in the same cycle.
- Undefined: ports ovr/ovr_clr are absent; behaviour is otherwise identical.

Test Plan:
- Reset: nrst=0 mid-CALC1 of section 2 → ce=0, c_we=0, out_vld=0 immediately; after release, samp_rdy=1 and the next sample is processed normally from section 0.
- Single sample, NUM_SEC=4: samp_vld at cycle 10 → din_le at 10; ce pattern 0001,0001,0000,0010,0010,0000,...; mult_sel 0,1,0 repeating; out_vld only at cycle 22.
- Coef load: cfg_vld with sec=2, addr=01, data=16'h1234 → one cycle c_we=0100, c_addr=01, c_in=1234; cfg_sec=5 with SEC_W=3 → c_we=0, cfg_err pulse.
- Collision: samp_vld and cfg_vld both high in IDLE → sample runs first (cfg_rdy=0); cfg write is issued the cycle after out_vld.
- Back-to-back: samp_vld held high continuously → samples accepted every 13 cycles (NUM_SEC=4); no ce overlap; out_vld count equals din_le count.
- IIR_CTRL_OVERRUN_EN: new samp_vld asserted while busy → ovr=1 and held; ovr_clr pulse → 0; clr and set in the same cycle → 0.

Source files
------------

// File: rtl/iir_sos_ctrl_if.sv
// Control bus of the biquad cascade sequencer: sample handshake, host coefficient port
// and the shared section bus (ce / mult_sel / c_we / c_addr / c_in).
interface iir_sos_ctrl_if #(
    parameter int NUM_SEC = 4,
    parameter int SEC_W   = 2,
    parameter int COEFF_W = 16
);
    logic               samp_vld;
    logic               samp_rdy;
    logic               din_le;
    logic               cfg_vld;
    logic               cfg_rdy;
    logic [SEC_W-1:0]   cfg_sec;
    logic [1:0]         cfg_addr;
    logic [COEFF_W-1:0] cfg_data;
    logic [NUM_SEC-1:0] ce;
    logic               mult_sel;
    logic [NUM_SEC-1:0] c_we;
    logic [1:0]         c_addr;
    logic [COEFF_W-1:0] c_in;
    logic               out_vld;
    logic               busy;
    logic               cfg_err;

    modport master (
        output samp_vld, cfg_vld, cfg_sec, cfg_addr, cfg_data,
        input  samp_rdy, din_le, cfg_rdy, ce, mult_sel, c_we, c_addr, c_in,
               out_vld, busy, cfg_err
    );

    modport slave (
        input  samp_vld, cfg_vld, cfg_sec, cfg_addr, cfg_data,
        output samp_rdy, din_le, cfg_rdy, ce, mult_sel, c_we, c_addr, c_in,
               out_vld, busy, cfg_err
    );
endinterface

// File: rtl/iir_sos_ctrl.sv
// Sequencer and coefficient loader for a cascade of NUM_SEC biquad sections.
// Optional overrun flag (ports ovr / ovr_clr) enabled by defining IIR_CTRL_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting; sample has priority over a coefficient write
// CFG   | one-cycle coefficient write pulse to the addressed section
// CALC0 | ce[sec_idx]=1, mult_sel=0
// CALC1 | ce[sec_idx]=1, mult_sel=1
// GAP   | ce low so section sec_idx latches; advance or finish
module iir_sos_ctrl #(
    parameter int NUM_SEC = 4,
    parameter int SEC_W   = 2,
    parameter int COEFF_W = 16
) (
    input  logic          c_clk,
    input  logic          nrst,
    iir_sos_ctrl_if.slave bus
`ifdef IIR_CTRL_OVERRUN_EN
    ,
    output logic          ovr,
    input  logic          ovr_clr
`endif
);

    typedef enum logic [2:0] {IDLE, CFG, CALC0, CALC1, GAP} state_t;

    localparam logic [SEC_W-1:0]   LAST_SEC  = SEC_W'(NUM_SEC - 1);
    localparam logic [SEC_W:0]     NUM_SEC_X = (SEC_W + 1)'(NUM_SEC);
    localparam logic [NUM_SEC-1:0] ONE_HOT0  = NUM_SEC'(1);

    state_t             state, state_nxt;
    logic [SEC_W-1:0]   sec_idx, sec_idx_nxt;
    logic [NUM_SEC-1:0] ce_q, ce_nxt;
    logic [NUM_SEC-1:0] c_we_q, c_we_nxt;
    logic [1:0]         c_addr_q, c_addr_nxt;
    logic [COEFF_W-1:0] c_in_q, c_in_nxt;
    logic               mult_sel_q, mult_sel_nxt;
    logic               din_le_q, din_le_nxt;
    logic               out_vld_q, out_vld_nxt;
    logic               busy_q, busy_nxt;
    logic               cfg_err_q, cfg_err_nxt;
    logic               cfg_take;
    logic               sec_ok;

    // Ready signals are the only combinational outputs; they never gate a clock.
    assign bus.samp_rdy = nrst && (state == IDLE);
    assign bus.cfg_rdy  = nrst && (state == IDLE) && !bus.samp_vld;

    always_comb begin
        state_nxt   = state;
        sec_idx_nxt = sec_idx;
        din_le_nxt  = 1'b0;
        out_vld_nxt = 1'b0;
        cfg_take    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.samp_vld) begin
                    state_nxt   = CALC0;
                    sec_idx_nxt = '0;
                    din_le_nxt  = 1'b1;
                end else if (bus.cfg_vld) begin
                    state_nxt = CFG;
                    cfg_take  = 1'b1;
                end
            end
            CFG:   state_nxt = IDLE;
            CALC0: state_nxt = CALC1;
            CALC1: state_nxt = GAP;
            GAP: begin
                if (sec_idx == LAST_SEC) begin
                    state_nxt   = IDLE;
                    out_vld_nxt = 1'b1;
                end else begin
                    state_nxt   = CALC0;
                    sec_idx_nxt = sec_idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops line up with the state.
        ce_nxt       = ((state_nxt == CALC0) || (state_nxt == CALC1)) ? (ONE_HOT0 << sec_idx_nxt) : '0;
        mult_sel_nxt = (state_nxt == CALC1);
        busy_nxt     = (state_nxt == CALC0) || (state_nxt == CALC1) || (state_nxt == GAP);

        sec_ok      = {1'b0, bus.cfg_sec} < NUM_SEC_X;
        c_we_nxt    = (cfg_take && sec_ok) ? (ONE_HOT0 << bus.cfg_sec) : '0;
        cfg_err_nxt = cfg_take && !sec_ok;
        c_addr_nxt  = cfg_take ? bus.cfg_addr : c_addr_q;
        c_in_nxt    = cfg_take ? bus.cfg_data : c_in_q;
    end

    always_ff @(posedge c_clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            sec_idx    <= '0;
            ce_q       <= '0;
            mult_sel_q <= 1'b0;
            c_we_q     <= '0;
            c_addr_q   <= '0;
            c_in_q     <= '0;
            din_le_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sec_idx    <= sec_idx_nxt;
            ce_q       <= ce_nxt;
            mult_sel_q <= mult_sel_nxt;
            c_we_q     <= c_we_nxt;
            c_addr_q   <= c_addr_nxt;
            c_in_q     <= c_in_nxt;
            din_le_q   <= din_le_nxt;
            out_vld_q  <= out_vld_nxt;
            busy_q     <= busy_nxt;
            cfg_err_q  <= cfg_err_nxt;
        end
    end

    assign bus.ce       = ce_q;
    assign bus.mult_sel = mult_sel_q;
    assign bus.c_we     = c_we_q;
    assign bus.c_addr   = c_addr_q;
    assign bus.c_in     = c_in_q;
    assign bus.din_le   = din_le_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.busy     = busy_q;
    assign bus.cfg_err  = cfg_err_q;

`ifdef IIR_CTRL_OVERRUN_EN
    logic samp_vld_q;

    // A sample that newly appears while we cannot take it is an overrun; clear wins.
    always_ff @(posedge c_clk or negedge nrst) begin
        if (!nrst) begin
            samp_vld_q <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            samp_vld_q <= bus.samp_vld;
            if (ovr_clr)
                ovr <= 1'b0;
            else if (bus.samp_vld && !bus.samp_rdy && !samp_vld_q)
                ovr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iir_sos_ctrl.sv
// Self-checking bench for iir_sos_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a sample/phase-counting reference model.
module tb_iir_sos_ctrl;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam int CW = 16;
    localparam logic [N-1:0] ONE = N'(1);

    logic c_clk = 1'b0;
    logic nrst;
    always #5 c_clk = ~c_clk;

    iir_sos_ctrl_if #(.NUM_SEC(N), .SEC_W(SW), .COEFF_W(CW)) bus();

`ifdef IIR_CTRL_OVERRUN_EN
    logic ovr;
    logic ovr_clr = 1'b0;
`endif

    iir_sos_ctrl #(.NUM_SEC(N), .SEC_W(SW), .COEFF_W(CW)) dut (
        .c_clk (c_clk),
        .nrst  (nrst),
        .bus   (bus.slave)
`ifdef IIR_CTRL_OVERRUN_EN
        ,
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: m_k counts cycles since din_le of the sample in flight (-1 = none).
    int              m_k;
    bit              m_cfg;
    bit              m_din_le, m_out_vld, m_err;
    logic [N-1:0]    m_we;
    logic [1:0]      m_addr;
    logic [CW-1:0]   m_data;
    bit              m_ovr, m_prev_sv;

    task automatic model_reset();
        m_k = -1; m_cfg = 0; m_din_le = 0; m_out_vld = 0; m_err = 0;
        m_we = '0; m_addr = '0; m_data = '0; m_ovr = 0; m_prev_sv = 0;
    endtask

    function automatic logic [33:0] exp_vec();
        logic idle, ms, ov;
        logic [N-1:0] ce_e;
        idle = (m_k < 0) && !m_cfg && (nrst === 1'b1);
        ce_e = '0;
        if (m_k >= 0 && (m_k % 3) != 2) ce_e = ONE << (m_k / 3);
        ms = (m_k >= 0) && ((m_k % 3) == 1);
        ov = 1'b0;
`ifdef IIR_CTRL_OVERRUN_EN
        ov = m_ovr;
`endif
        return {idle, idle && !bus.samp_vld, m_din_le, (m_k >= 0), m_out_vld, m_err, ms,
                ce_e, m_we, m_addr, m_data, ov};
    endfunction

    function automatic logic [33:0] obs_vec();
        logic ov;
        ov = 1'b0;
`ifdef IIR_CTRL_OVERRUN_EN
        ov = ovr;
`endif
        return {bus.samp_rdy, bus.cfg_rdy, bus.din_le, bus.busy, bus.out_vld, bus.cfg_err,
                bus.mult_sel, bus.ce, bus.c_we, bus.c_addr, bus.c_in, ov};
    endfunction

    task automatic drive(input bit sv, input bit cv, input logic [SW-1:0] sec,
                         input logic [1:0] addr, input logic [CW-1:0] data);
        bus.samp_vld = sv;
        bus.cfg_vld  = cv;
        bus.cfg_sec  = sec;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        #1;
    endtask

    // Apply the clock edge to the model, then move to the next sampling point.
    task automatic advance();
        bit idle;
        idle = (m_k < 0) && !m_cfg;
`ifdef IIR_CTRL_OVERRUN_EN
        if (ovr_clr) m_ovr = 0;
        else if (bus.samp_vld && !idle && !m_prev_sv) m_ovr = 1;
        m_prev_sv = bus.samp_vld;
`endif
        m_din_le = 0; m_out_vld = 0; m_err = 0; m_we = '0;
        if (m_cfg) m_cfg = 0;
        else if (m_k >= 0) begin
            if (m_k == 3 * N - 1) begin m_k = -1; m_out_vld = 1; end
            else m_k++;
        end else if (bus.samp_vld) begin
            m_k = 0; m_din_le = 1;
        end else if (bus.cfg_vld) begin
            m_cfg = 1; m_addr = bus.cfg_addr; m_data = bus.cfg_data;
            if (int'(bus.cfg_sec) < N) m_we = ONE << bus.cfg_sec;
            else m_err = 1;
        end
        @(negedge c_clk);
        cyc++;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3 * N + 4 && !((m_k < 0) && !m_cfg); i++) begin
            drive(0, 0, '0, '0, '0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_drain: got %h expected %h", name, obs_vec(), exp_vec());
            end
            advance();
        end
        n_tests++;
        if (!((m_k < 0) && !m_cfg)) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: model still busy k=%0d", name, m_k);
        end
    endtask

    task automatic test_reset();
        int ov_cnt;
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (obs_vec() !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        @(negedge c_clk);
        nrst = 1'b1;
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (bus.samp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_rdy: got %b expected 1", bus.samp_rdy);
        end
        advance();
        drive(1, 0, '0, '0, '0);
        advance();
        for (int i = 0; i < 20 && m_k != 7; i++) begin
            drive(0, 0, '0, '0, '0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_pre: got %h expected %h", obs_vec(), exp_vec());
            end
            advance();
        end
        n_tests++;
        if (bus.ce !== 4'b0100 || bus.mult_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_at_calc1_sec2: ce=%b ms=%b expected 0100/1", bus.ce, bus.mult_sel);
        end
        #2 nrst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid_sample: got %h expected 0", obs_vec());
        end
        @(negedge c_clk);
        nrst = 1'b1;
        drive(1, 0, '0, '0, '0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_restart: got %h expected %h", obs_vec(), exp_vec());
        end
        advance();
        n_tests++;
        if (bus.ce !== 4'b0001 || bus.din_le !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_restart_sec0: ce=%b din_le=%b expected 0001/1", bus.ce, bus.din_le);
        end
        ov_cnt = 0;
        for (int i = 0; i < 3 * N + 2; i++) begin
            drive(0, 0, '0, '0, '0);
            if (bus.out_vld === 1'b1) ov_cnt++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_after: got %h expected %h", obs_vec(), exp_vec());
            end
            advance();
        end
        n_tests++;
        if (ov_cnt != 1) begin
            n_fail++;
            $display("FAIL reset_after_out_vld_count: got %0d expected 1", ov_cnt);
        end
    endtask

    task automatic test_single_sample();
        logic [N-1:0] ce_tab [6];
        logic         ms_tab [6];
        int dl_cyc, ov_cyc;
        ce_tab = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        ms_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        dl_cyc = -1; ov_cyc = -1;
        drive(1, 0, '0, '0, '0);
        advance();
        for (int i = 0; i < 3 * N + 3; i++) begin
            drive(0, 0, '0, '0, '0);
            if (bus.din_le === 1'b1) dl_cyc = cyc;
            if (bus.out_vld === 1'b1) ov_cyc = cyc;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i < 6) begin
                n_tests++;
                if (bus.ce !== ce_tab[i] || bus.mult_sel !== ms_tab[i]) begin
                    n_fail++;
                    $display("FAIL single_pattern%0d: ce=%b ms=%b expected %b/%b",
                             i, bus.ce, bus.mult_sel, ce_tab[i], ms_tab[i]);
                end
            end
            advance();
        end
        n_tests++;
        if (dl_cyc < 0 || ov_cyc - dl_cyc != 3 * N) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected %0d", ov_cyc - dl_cyc, 3 * N);
        end
    endtask

    task automatic test_coef_load();
        drive(0, 1, 3'd2, 2'b01, 16'h1234);
        n_tests++;
        if (bus.cfg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL coef_rdy: got %b expected 1", bus.cfg_rdy);
        end
        advance();
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (bus.c_we !== 4'b0100 || bus.c_addr !== 2'b01 || bus.c_in !== 16'h1234 || bus.ce !== '0) begin
            n_fail++;
            $display("FAIL coef_write: we=%b addr=%b data=%h expected 0100/01/1234", bus.c_we, bus.c_addr, bus.c_in);
        end
        advance();
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (bus.c_we !== 4'b0000 || bus.c_addr !== 2'b01 || bus.c_in !== 16'h1234) begin
            n_fail++;
            $display("FAIL coef_hold: we=%b addr=%b data=%h expected 0000/01/1234", bus.c_we, bus.c_addr, bus.c_in);
        end
        drive(0, 1, 3'd5, 2'b10, 16'hBEEF);
        advance();
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (bus.c_we !== 4'b0000 || bus.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL coef_bad_sec: we=%b err=%b expected 0000/1", bus.c_we, bus.cfg_err);
        end
        advance();
        drive(0, 1, 3'd1, 2'b11, 16'h00A5);
        n_tests++;
        if (bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL coef_err_pulse: got %b expected 0", bus.cfg_err);
        end
        advance();
        drive(0, 0, '0, '0, '0);
        n_tests++;
        if (bus.c_we !== 4'b0010 || bus.c_addr !== 2'b11 || bus.c_in !== 16'h00A5) begin
            n_fail++;
            $display("FAIL coef_addr11: we=%b addr=%b data=%h expected 0010/11/00a5", bus.c_we, bus.c_addr, bus.c_in);
        end
        advance();
    endtask

    task automatic test_collision();
        int ov_cyc, we_cyc;
        bit cv;
        logic [N-1:0] we_seen;
        ov_cyc = -1; we_cyc = -1; we_seen = '0; cv = 1;
        drive(1, 1, 3'd3, 2'b10, 16'hCAFE);
        n_tests++;
        if (bus.cfg_rdy !== 1'b0 || bus.samp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_rdy: cfg_rdy=%b samp_rdy=%b expected 0/1", bus.cfg_rdy, bus.samp_rdy);
        end
        advance();
        for (int i = 0; i < 3 * N + 4; i++) begin
            drive(0, cv, 3'd3, 2'b10, 16'hCAFE);
            if (bus.out_vld === 1'b1) ov_cyc = cyc;
            if (bus.c_we !== '0 && we_cyc < 0) begin we_cyc = cyc; we_seen = bus.c_we; end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL collide_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            advance();
            if (m_cfg) cv = 0;
        end
        n_tests++;
        if (ov_cyc < 0 || we_cyc != ov_cyc + 1 || we_seen !== 4'b1000) begin
            n_fail++;
            $display("FAIL collide_order: out_vld@%0d we@%0d we=%b expected we@out_vld+1 1000",
                     ov_cyc, we_cyc, we_seen);
        end
        drain("collide");
    endtask

    task automatic test_back_to_back();
        int dl_cnt, ov_cnt, last_dl;
        dl_cnt = 0; ov_cnt = 0; last_dl = -1;
        for (int i = 0; i < 80 + 3 * N + 2; i++) begin
            drive(i < 80, 0, '0, '0, '0);
            if (bus.out_vld === 1'b1) ov_cnt++;
            if (bus.din_le === 1'b1) begin
                if (last_dl >= 0) begin
                    n_tests++;
                    if (cyc - last_dl != 3 * N + 1) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d expected %0d", cyc - last_dl, 3 * N + 1);
                    end
                end
                last_dl = cyc;
                dl_cnt++;
            end
            n_tests++;
            if (obs_vec() !== exp_vec() || !$onehot0(bus.ce)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
        n_tests++;
        if (dl_cnt != 7 || ov_cnt != dl_cnt) begin
            n_fail++;
            $display("FAIL b2b_counts: din_le=%0d out_vld=%0d expected 7/7", dl_cnt, ov_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
`ifdef IIR_CTRL_OVERRUN_EN
            ovr_clr = ($urandom_range(0, 15) == 0);
`endif
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, SW'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), CW'($urandom));
            n_tests++;
            if (obs_vec() !== exp_vec() || !$onehot0(bus.ce) || (bus.ce !== '0 && bus.c_we !== '0)) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            advance();
        end
`ifdef IIR_CTRL_OVERRUN_EN
        ovr_clr = 1'b0;
`endif
        drain("random");
    endtask

`ifdef IIR_CTRL_OVERRUN_EN
    task automatic test_overrun();
        bit sv_tab [10];
        bit clr_tab [10];
        sv_tab  = '{1, 0, 0, 1, 1, 1, 1, 0, 1, 0};
        clr_tab = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            ovr_clr = clr_tab[i];
            drive(sv_tab[i], 0, '0, '0, '0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovr_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 4 || i == 5 || i == 6 || i == 7 || i == 9) begin
                n_tests++;
                if (ovr !== ((i >= 4 && i <= 6) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL ovr_flag%0d: got %b expected %b", i, ovr, (i >= 4 && i <= 6));
                end
            end
            advance();
        end
        ovr_clr = 1'b0;
        drain("ovr");
    endtask
`endif

    initial begin
        nrst = 1'b1;
        model_reset();
        #1 nrst = 1'b0;
        @(negedge c_clk);
        test_reset();
        test_single_sample();
        test_coef_load();
        test_collision();
        test_back_to_back();
`ifdef IIR_CTRL_OVERRUN_EN
        test_overrun();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
